// File: rtl/issue_queue_pkg.sv
// Shared types and helpers for the collapsing issue queue (default widths, depth
// counter width, lowest-index priority encoder).
package issue_queue_pkg;

  localparam int IQ_DEPTH      = 4;
  localparam int IQ_NUM_UNITS  = 8;
  localparam int IQ_READ_PORTS = 2;
  localparam int IQ_NUM_WB     = 2;
  localparam int IQ_PHYS_W     = 6;
  localparam int IQ_PAYLOAD_W  = 64;
  localparam int IQ_MAX_DEPTH  = 32;

  // Entry layout at the default widths; the queue re-declares it with its own parameters.
  typedef struct packed {
    logic                                valid;
    logic [IQ_NUM_UNITS-1:0]             unit;
    logic [IQ_READ_PORTS-1:0]            uses_rs;
    logic [IQ_READ_PORTS-1:0]            pending;
    logic [IQ_READ_PORTS*IQ_PHYS_W-1:0]  phys_rs;
    logic [IQ_PAYLOAD_W-1:0]             payload;
  } iq_entry_t;

  function automatic int IQ_DEPTH_W(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic logic [4:0] iq_priority_enc(input logic [IQ_MAX_DEPTH-1:0] req);
    iq_priority_enc = '0;
    for (int i = IQ_MAX_DEPTH - 1; i >= 0; i--) begin
      if (req[i]) iq_priority_enc = 5'(i);
    end
  endfunction

endpackage

// File: rtl/issue_queue_if.sv
// Decode/wakeup/issue signal bundle for the issue queue; master = surrounding
// pipeline, slave = the queue.
interface issue_queue_if #(
  parameter int DEPTH      = issue_queue_pkg::IQ_DEPTH,
  parameter int NUM_UNITS  = issue_queue_pkg::IQ_NUM_UNITS,
  parameter int READ_PORTS = issue_queue_pkg::IQ_READ_PORTS,
  parameter int NUM_WB     = issue_queue_pkg::IQ_NUM_WB,
  parameter int PHYS_W     = issue_queue_pkg::IQ_PHYS_W,
  parameter int PAYLOAD_W  = issue_queue_pkg::IQ_PAYLOAD_W
);
  localparam int OCC_W = issue_queue_pkg::IQ_DEPTH_W(DEPTH);

  logic                         enq_valid;
  logic                         enq_ready;
  logic [NUM_UNITS-1:0]         enq_unit;
  logic [READ_PORTS-1:0]        enq_uses_rs;
  logic [READ_PORTS-1:0]        enq_rs_pending;
  logic [READ_PORTS*PHYS_W-1:0] enq_phys_rs;
  logic [PAYLOAD_W-1:0]         enq_payload;
  logic [NUM_WB-1:0]            wb_valid;
  logic [NUM_WB*PHYS_W-1:0]     wb_phys_rd;
  logic [NUM_UNITS-1:0]         unit_ready;
  logic                         issue_hold;
  logic                         fetch_flush;
  logic [NUM_UNITS-1:0]         issue_to;
  logic                         issue_valid;
  logic [PAYLOAD_W-1:0]         issue_payload;
  logic [READ_PORTS*PHYS_W-1:0] issue_phys_rs;
  logic [OCC_W-1:0]             occupancy;

  modport master (
    output enq_valid, enq_unit, enq_uses_rs, enq_rs_pending, enq_phys_rs, enq_payload,
    output wb_valid, wb_phys_rd, unit_ready, issue_hold, fetch_flush,
    input  enq_ready, issue_to, issue_valid, issue_payload, issue_phys_rs, occupancy
  );

  modport slave (
    input  enq_valid, enq_unit, enq_uses_rs, enq_rs_pending, enq_phys_rs, enq_payload,
    input  wb_valid, wb_phys_rd, unit_ready, issue_hold, fetch_flush,
    output enq_ready, issue_to, issue_valid, issue_payload, issue_phys_rs, occupancy
  );

endinterface

// File: rtl/iq_wakeup_match.sv
// Compares one entry's source tags against every writeback port and returns the
// per-source pending-clear mask.
module iq_wakeup_match #(
  parameter int READ_PORTS = 2,
  parameter int NUM_WB     = 2,
  parameter int PHYS_W     = 6
) (
  input  logic [READ_PORTS*PHYS_W-1:0] phys_rs,
  input  logic [NUM_WB-1:0]            wb_valid,
  input  logic [NUM_WB*PHYS_W-1:0]     wb_phys_rd,
  output logic [READ_PORTS-1:0]        clear
);

  always_comb begin
    clear = '0;
    for (int j = 0; j < READ_PORTS; j++) begin
      for (int k = 0; k < NUM_WB; k++) begin
        if (wb_valid[k] && (phys_rs[j*PHYS_W +: PHYS_W] == wb_phys_rd[k*PHYS_W +: PHYS_W]))
          clear[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/issue_queue.sv
// Collapsing DEPTH-entry issue queue: oldest-ready-first select with writeback wakeup.
// Define ISSUE_QUEUE_IN_ORDER_EN to restrict selection to the head entry (strict in-order issue).
module issue_queue
  import issue_queue_pkg::*;
#(
  parameter int DEPTH      = IQ_DEPTH,
  parameter int NUM_UNITS  = IQ_NUM_UNITS,
  parameter int READ_PORTS = IQ_READ_PORTS,
  parameter int NUM_WB     = IQ_NUM_WB,
  parameter int PHYS_W     = IQ_PHYS_W,
  parameter int PAYLOAD_W  = IQ_PAYLOAD_W
) (
  input logic          clk,
  input logic          rst,
  issue_queue_if.slave io
);

  localparam int CNT_W = IQ_DEPTH_W(DEPTH);
  localparam int IDX_W = $clog2(DEPTH);

  typedef struct packed {
    logic                         valid;
    logic [NUM_UNITS-1:0]         unit;
    logic [READ_PORTS-1:0]        uses_rs;
    logic [READ_PORTS-1:0]        pending;
    logic [READ_PORTS*PHYS_W-1:0] phys_rs;
    logic [PAYLOAD_W-1:0]         payload;
  } entry_t;

  entry_t                q          [DEPTH];
  entry_t                q_next     [DEPTH];
  logic [READ_PORTS-1:0] wake_clear [DEPTH];
  logic [READ_PORTS-1:0] enq_wake_clear;
  logic [CNT_W-1:0]      count, count_next;
  logic [DEPTH-1:0]      cand;
  logic [IDX_W-1:0]      sel_idx, wr_idx;
  logic                  sel_found, issue_fire, enq_fire;

  for (genvar g = 0; g < DEPTH; g++) begin : g_wake
    iq_wakeup_match #(.READ_PORTS(READ_PORTS), .NUM_WB(NUM_WB), .PHYS_W(PHYS_W)) u_match (
      .phys_rs    (q[g].phys_rs),
      .wb_valid   (io.wb_valid),
      .wb_phys_rd (io.wb_phys_rd),
      .clear      (wake_clear[g])
    );
  end

  iq_wakeup_match #(.READ_PORTS(READ_PORTS), .NUM_WB(NUM_WB), .PHYS_W(PHYS_W)) u_enq_match (
    .phys_rs    (io.enq_phys_rs),
    .wb_valid   (io.wb_valid),
    .wb_phys_rd (io.wb_phys_rd),
    .clear      (enq_wake_clear)
  );

  // An entry is a candidate when all used sources are available and its unit can accept.
  always_comb begin
    cand = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cand[i] = q[i].valid & (&(~q[i].pending | ~q[i].uses_rs)) & (|(q[i].unit & io.unit_ready));
    end
`ifdef ISSUE_QUEUE_IN_ORDER_EN
    cand[DEPTH-1:1] = '0;
`else
`endif
  end

  assign sel_found        = |cand;
  assign sel_idx          = IDX_W'(iq_priority_enc(IQ_MAX_DEPTH'(cand)));
  assign issue_fire       = sel_found & ~io.issue_hold & ~io.fetch_flush;
  assign io.issue_to      = issue_fire ? q[sel_idx].unit : '0;
  assign io.issue_valid   = |io.issue_to;
  assign io.issue_payload = q[sel_idx].payload;
  assign io.issue_phys_rs = q[sel_idx].phys_rs;
  assign io.occupancy     = count;
  assign io.enq_ready     = (count != CNT_W'(DEPTH));
  assign enq_fire         = io.enq_valid & io.enq_ready & ~io.fetch_flush;
  assign wr_idx           = IDX_W'(count - CNT_W'(issue_fire));

  // Wake every entry, collapse the hole left by an issue, then append at the new tail.
  always_comb begin
    q_next = q;
    for (int i = 0; i < DEPTH; i++) begin
      q_next[i].pending = q[i].pending & ~wake_clear[i];
    end
    if (issue_fire) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (i >= int'(sel_idx)) begin
          q_next[i]         = q[i+1];
          q_next[i].pending = q[i+1].pending & ~wake_clear[i+1];
        end
      end
      q_next[DEPTH-1].valid = 1'b0;
    end
    if (enq_fire) begin
      q_next[wr_idx].valid   = 1'b1;
      q_next[wr_idx].unit    = io.enq_unit;
      q_next[wr_idx].uses_rs = io.enq_uses_rs;
      q_next[wr_idx].pending = io.enq_rs_pending & ~enq_wake_clear;
      q_next[wr_idx].phys_rs = io.enq_phys_rs;
      q_next[wr_idx].payload = io.enq_payload;
    end
    count_next = count - CNT_W'(issue_fire) + CNT_W'(enq_fire);
  end

  // Only valid bits and the count are cleared; payload state is don't-care once invalid.
  always_ff @(posedge clk) begin
    if (rst || io.fetch_flush) begin
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q[i].valid <= 1'b0;
      end
    end else begin
      count <= count_next;
      q     <= q_next;
    end
  end

endmodule

// File: tb/tb_issue_queue.sv
// Self-checking bench for issue_queue: a queue-level reference model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_issue_queue;

  localparam int DEPTH = 4;
  localparam logic [7:0] ALU = 8'h01;
  localparam logic [7:0] MUL = 8'h02;
  localparam logic [7:0] DIV = 8'h04;

  typedef struct packed {
    logic [7:0]  unit;
    logic [1:0]  uses;
    logic [1:0]  pend;
    logic [11:0] rs;
    logic [63:0] pl;
  } m_entry_t;

  logic     clk = 1'b0;
  logic     rst;
  int       checks = 0;
  int       failures = 0;
  m_entry_t mq[$];

  issue_queue_if #(.DEPTH(DEPTH)) io ();

  issue_queue #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  always #5 clk = ~clk;

  task automatic compare(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_woken(input logic [5:0] r);
    for (int k = 0; k < 2; k++) begin
      if (io.wb_valid[k] && io.wb_phys_rd[k*6 +: 6] == r) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic bit m_ready(input m_entry_t e);
    for (int j = 0; j < 2; j++) begin
      if (e.uses[j] && e.pend[j]) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Oldest entry that is ready and whose unit is free; -1 if none.
  function automatic int m_select();
    int lim = mq.size();
`ifdef ISSUE_QUEUE_IN_ORDER_EN
    if (lim > 1) lim = 1;
`else
`endif
    for (int i = 0; i < lim; i++) begin
      if (m_ready(mq[i]) && |(mq[i].unit & io.unit_ready)) return i;
    end
    return -1;
  endfunction

  task automatic checkOutput();
    int         s;
    logic [7:0] exp_to;
    s      = m_select();
    exp_to = (s >= 0 && !io.issue_hold && !io.fetch_flush) ? mq[s].unit : 8'h00;
    compare("issue_to", io.issue_to, exp_to);
    compare("issue_valid", io.issue_valid, exp_to != 8'h00);
    compare("occupancy", io.occupancy, mq.size());
    compare("enq_ready", io.enq_ready, mq.size() != DEPTH);
    if (exp_to != 8'h00) begin
      compare("issue_payload", io.issue_payload, mq[s].pl);
      compare("issue_phys_rs", io.issue_phys_rs, mq[s].rs);
    end
  endtask

  task automatic modelStep();
    int       s;
    bit       room;
    m_entry_t e;
    if (rst || io.fetch_flush) begin
      mq.delete();
    end else begin
      s    = m_select();
      room = mq.size() != DEPTH;
      for (int i = 0; i < mq.size(); i++) begin
        e = mq[i];
        for (int j = 0; j < 2; j++) if (m_woken(e.rs[j*6 +: 6])) e.pend[j] = 1'b0;
        mq[i] = e;
      end
      if (s >= 0 && !io.issue_hold) mq.delete(s);
      if (io.enq_valid && room) begin
        e = '{unit: io.enq_unit, uses: io.enq_uses_rs, pend: io.enq_rs_pending,
              rs: io.enq_phys_rs, pl: io.enq_payload};
        for (int j = 0; j < 2; j++) if (m_woken(e.rs[j*6 +: 6])) e.pend[j] = 1'b0;
        mq.push_back(e);
      end
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] unit, input logic [1:0] uses,
                               input logic [1:0] pend, input logic [11:0] rs, input logic [63:0] pl);
    io.enq_valid      = v;
    io.enq_unit       = unit;
    io.enq_uses_rs    = uses;
    io.enq_rs_pending = pend;
    io.enq_phys_rs    = rs;
    io.enq_payload    = pl;
  endtask

  task automatic clearInputs();
    applyStimulus(1'b0, 8'h00, 2'b00, 2'b00, 12'h000, 64'h0);
    io.wb_valid    = 2'b00;
    io.wb_phys_rd  = 12'h000;
    io.unit_ready  = 8'hFF;
    io.issue_hold  = 1'b0;
    io.fetch_flush = 1'b0;
  endtask

  task automatic tick();
    #1;
    checkOutput();
    @(posedge clk);
    modelStep();
    @(negedge clk);
  endtask

  initial begin
    clearInputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    compare("reset occupancy", io.occupancy, 0);
    compare("reset enq_ready", io.enq_ready, 1);
    compare("reset issue_valid", io.issue_valid, 0);
    compare("reset issue_to", io.issue_to, 0);
    rst = 1'b0;

    // Fill under hold, then drain in order.
    io.issue_hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, ALU, 2'b00, 2'b00, 12'(i), 64'h100 + 64'(i));
      tick();
    end
    applyStimulus(1'b0, 8'h00, 2'b00, 2'b00, 12'h000, 64'h0);
    #1;
    compare("full occupancy", io.occupancy, 4);
    compare("full enq_ready", io.enq_ready, 0);
    io.issue_hold = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      compare("drain order payload", io.issue_payload, 64'h100 + 64'(i));
      compare("drain issue_to", io.issue_to, ALU);
      tick();
    end
    #1;
    compare("drained occupancy", io.occupancy, 0);

    // Pending head, independent younger op on another unit.
    applyStimulus(1'b1, MUL, 2'b01, 2'b01, {6'd0, 6'd5}, 64'hA);
    tick();
    applyStimulus(1'b1, ALU, 2'b00, 2'b00, 12'h000, 64'hB);
    tick();
    applyStimulus(1'b0, 8'h00, 2'b00, 2'b00, 12'h000, 64'h0);
    #1;
`ifdef ISSUE_QUEUE_IN_ORDER_EN
    compare("in-order B waits", io.issue_valid, 0);
`else
    compare("B bypasses A", io.issue_payload, 64'hB);
    compare("B bypasses A valid", io.issue_valid, 1);
`endif
    tick();
    io.wb_valid   = 2'b01;
    io.wb_phys_rd = {6'd0, 6'd5};
    #1;
    compare("A not yet woken", io.issue_valid, 0);
    tick();
    io.wb_valid = 2'b00;
    #1;
    compare("A issues after wakeup", io.issue_payload, 64'hA);
    compare("A unit", io.issue_to, MUL);
    tick();
    #1;
`ifdef ISSUE_QUEUE_IN_ORDER_EN
    compare("B issues after A", io.issue_payload, 64'hB);
`else
    compare("queue empty after A", io.issue_valid, 0);
`endif
    tick();

    // Same-cycle wakeup on enqueue; unused pending source ignored.
    applyStimulus(1'b1, DIV, 2'b01, 2'b11, {6'd7, 6'd9}, 64'h300);
    io.wb_valid   = 2'b10;
    io.wb_phys_rd = {6'd9, 6'd3};
    tick();
    applyStimulus(1'b0, 8'h00, 2'b00, 2'b00, 12'h000, 64'h0);
    io.wb_valid = 2'b00;
    #1;
    compare("enq-cycle wakeup issues", io.issue_payload, 64'h300);
    compare("enq-cycle wakeup phys", io.issue_phys_rs, {6'd7, 6'd9});
    tick();

    // Full queue with issue and offered enqueue in the same cycle.
    io.issue_hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, ALU, 2'b00, 2'b00, 12'h000, 64'h200 + 64'(i));
      tick();
    end
    io.issue_hold = 1'b0;
    applyStimulus(1'b1, ALU, 2'b00, 2'b00, 12'h000, 64'h2FF);
    #1;
    compare("full+issue enq_ready", io.enq_ready, 0);
    compare("full+issue issues", io.issue_valid, 1);
    tick();
    applyStimulus(1'b0, 8'h00, 2'b00, 2'b00, 12'h000, 64'h0);
    io.issue_hold = 1'b1;
    #1;
    compare("full+issue occupancy", io.occupancy, 3);
    io.issue_hold = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    #1;
    compare("full drain empty", io.occupancy, 0);

    // Flush with a ready candidate and an offered enqueue.
    io.issue_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, ALU, 2'b00, 2'b00, 12'h000, 64'h400 + 64'(i));
      tick();
    end
    io.issue_hold  = 1'b0;
    io.fetch_flush = 1'b1;
    applyStimulus(1'b1, ALU, 2'b00, 2'b00, 12'h000, 64'h4FF);
    #1;
    compare("flush suppresses issue", io.issue_to, 0);
    tick();
    io.fetch_flush = 1'b0;
    applyStimulus(1'b0, 8'h00, 2'b00, 2'b00, 12'h000, 64'h0);
    #1;
    compare("flush occupancy", io.occupancy, 0);
    tick();

    // Busy unit on the head lets a younger op through.
    io.unit_ready = 8'hFE;
    applyStimulus(1'b1, ALU, 2'b00, 2'b00, 12'h000, 64'h500);
    tick();
    applyStimulus(1'b1, DIV, 2'b00, 2'b00, 12'h000, 64'h501);
    tick();
    applyStimulus(1'b0, 8'h00, 2'b00, 2'b00, 12'h000, 64'h0);
    #1;
`ifdef ISSUE_QUEUE_IN_ORDER_EN
    compare("busy head blocks", io.issue_valid, 0);
`else
    compare("busy head bypassed", io.issue_to, DIV);
`endif
    tick();
    io.unit_ready = 8'hFF;
    for (int i = 0; i < 3; i++) tick();

    // Reset mid-operation with an in-flight wakeup.
    io.issue_hold = 1'b1;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, MUL, 2'b01, 2'b01, {6'd0, 6'd12}, 64'h600 + 64'(i));
      tick();
    end
    applyStimulus(1'b0, 8'h00, 2'b00, 2'b00, 12'h000, 64'h0);
    rst           = 1'b1;
    io.wb_valid   = 2'b01;
    io.wb_phys_rd = {6'd0, 6'd12};
    tick();
    rst           = 1'b0;
    io.wb_valid   = 2'b00;
    io.issue_hold = 1'b0;
    #1;
    compare("mid reset occupancy", io.occupancy, 0);
    compare("mid reset enq_ready", io.enq_ready, 1);
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
